// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack fetch FSM, decoded fields
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   imem_req, imem_addr   fetch request and address (address is the PC)
//   imem_ack, imem_rdata  memory acknowledge and returned instruction word
//   Instr, Cond, Op,      registered instruction word and its field slices
//   Funct, Rd
//   instr_valid           Instr holds a live instruction
//   instr_ready           downstream retires the current instruction
//   PCSrc, branch_target  redirect select and target, sampled on retire only
//   PC, PCPlus8           current instruction address and PC + 8
//   fetch_err             one-cycle pulse when a request times out
//   instr_count           retired-instruction counter
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      Instr,
  output logic [3:0]       Cond,
  output logic [1:0]       Op,
  output logic [5:0]       Funct,
  output logic [3:0]       Rd,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             PCSrc,
  input  logic [31:0]      branch_target,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus8,
  output logic             fetch_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_hit;
  logic              retire;

  // An ack on the terminal-count cycle takes priority over the timeout.
  assign timeout_hit = (state == S_REQ) && !imem_ack && (wait_cnt == WAIT_LAST);
  assign retire      = (state == S_VALID) && instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          state_nxt = S_VALID;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_VALID: begin
        if (instr_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    if (state == S_REQ) begin
      imem_req = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PC          <= RESET_PC;
      Instr       <= 32'h0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      instr_count <= '0;
      wait_cnt    <= '0;
    end else begin
      fetch_err <= timeout_hit;

      if (state == S_REQ) begin
        if (imem_ack) begin
          Instr       <= imem_rdata;
          instr_valid <= 1'b1;
          wait_cnt    <= '0;
        end else if (timeout_hit) begin
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end

      if (retire) begin
        // Redirect targets are forced word-aligned.
        PC          <= PCSrc ? (branch_target & 32'hFFFF_FFFC) : PC + 32'd4;
        instr_count <= instr_count + CNT_W'(1);
        instr_valid <= 1'b0;
      end
    end
  end

  assign imem_addr = PC;
  assign PCPlus8   = PC + 32'd8;
  assign Cond      = Instr[31:28];
  assign Op        = Instr[27:26];
  assign Funct     = Instr[25:20];
  assign Rd        = Instr[15:12];

endmodule
